// File: rtl/queen_solution_collector.sv
// queen_solution_collector: captures one-hot queen rows, packs 8 column indices into a word, buffers words in a FIFO
// Ports: clk/reset (async active-low), clear (sync flush); row_valid/row_bus row capture input;
// row_ptr next row index; sol_valid/sol_ready/sol_data solution handoff; full, sol_count,
// onehot_err and overflow status, all registered or derived from registers only.
module queen_solution_collector #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               row_valid,
  input  logic [7:0]         row_bus,
  output logic               full,
  output logic [2:0]         row_ptr,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [23:0]        sol_data,
  output logic [COUNT_W-1:0] sol_count,
  output logic               onehot_err,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  logic [2:0]         row_ptr_q, row_ptr_d, col_raw, col;
  logic [23:0]        asm_q, asm_d;
  logic [23:0]        mem_q [DEPTH];
  logic [23:0]        mem_d [DEPTH];
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]        occ_q, occ_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d, ovf_q, ovf_d;
  logic               onehot, commit, pop, push;
  always_comb begin
    col_raw = '0;
    for (int k = 0; k < 8; k++)
      if (row_bus[k]) col_raw = 3'(k);
    onehot = $onehot(row_bus);
    col = onehot ? col_raw : 3'd0;
  end
  always_comb begin
    pop    = (occ_q != '0) && sol_ready;
    commit = row_valid && (row_ptr_q == 3'd7);
    // a full FIFO can still take the board if the head leaves on the same edge
    push   = commit && ((occ_q != FULL_OCC) || pop);
    asm_d  = asm_q;
    if (row_valid) asm_d[3*int'(row_ptr_q) +: 3] = col;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = asm_d;
    rd_d      = rd_q + AW'(pop);
    wr_d      = wr_q + AW'(push);
    occ_d     = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    row_ptr_d = row_ptr_q + 3'(row_valid);
    cnt_d     = (push && cnt_q != '1) ? cnt_q + COUNT_W'(1) : cnt_q;
    err_d     = err_q | (row_valid & ~onehot);
    ovf_d     = ovf_q | (commit & ~push);
    if (clear) begin
      asm_d     = '0;
      mem_d     = '{default: '0};
      rd_d      = '0;
      wr_d      = '0;
      occ_d     = '0;
      row_ptr_d = '0;
      cnt_d     = '0;
      err_d     = 1'b0;
      ovf_d     = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q     <= '0;
      mem_q     <= '{default: '0};
      rd_q      <= '0;
      wr_q      <= '0;
      occ_q     <= '0;
      row_ptr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      occ_q     <= occ_d;
      row_ptr_q <= row_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end
  assign full       = (occ_q == FULL_OCC);
  assign sol_valid  = (occ_q != '0);
  assign sol_data   = mem_q[rd_q];
  assign row_ptr    = row_ptr_q;
  assign sol_count  = cnt_q;
  assign onehot_err = err_q;
  assign overflow   = ovf_q;
endmodule
